dot_product_ctrl: RTL and testbench
===================================

DOT_PRODUCT_CTRL -- requirements
Module: dot_product_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 8, element width; VECTOR_WIDTH, 4, elements per vector; ADDR_WIDTH, 5, memory address width; ACC_WIDTH, 18, accumulator/result width; CNT_WIDTH, 3, element counter width.
REQ-002 Ports SHALL be:
clk  input  1  sole clock, all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
start  input  1  request one dot-product run
base_addr  input  ADDR_WIDTH  start address of both vectors, sampled with start
busy  output  1  run in progress (any state but IDLE)
rd_en_mem1  output  1  read enable, memory 1
rd_addr_mem1  output  ADDR_WIDTH  read address, memory 1
rd_en_mem2  output  1  read enable, memory 2
rd_addr_mem2  output  ADDR_WIDTH  read address, memory 2
mem1_rdata  input  DATA_WIDTH  memory 1 data, valid one cycle after rd_en_mem1
mem2_rdata  input  DATA_WIDTH  memory 2 data, valid one cycle after rd_en_mem2
element_count  output  CNT_WIDTH  products accumulated so far in current run
result  output  ACC_WIDTH  dot product
result_valid  output  1  result available
result_ready  input  1  consumer accepts result
REQ-003 Clock SHALL be the single clock clk; reset SHALL be rst_n, synchronous and active-low.

Function
REQ-004 FSM states SHALL be IDLE, READ, DRAIN, DONE; all outputs registered.
REQ-005 IDLE: start=1 at an edge SHALL latch base_addr, clear accumulator and element_count, go to READ.
REQ-006 READ: rd_en_mem1/2 SHALL be 1 for exactly VECTOR_WIDTH consecutive cycles, addresses base_addr+i (i=0..VECTOR_WIDTH-1), identical on both memories; then go to DRAIN.
REQ-007 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.
REQ-008 Each cycle after a cycle with rd_en=1, accumulator SHALL add mem1_rdata*mem2_rdata and element_count SHALL increment by 1.
REQ-009 DRAIN: one cycle, rd_en=0, final product accumulated; then DONE.
REQ-010 Latency: first rd_en 1 cycle after start sampled; result_valid=1 exactly VECTOR_WIDTH+2 cycles after start sampled.
REQ-011 DONE: result_valid=1, result and element_count (=VECTOR_WIDTH) held stable until result_valid&&result_ready at an edge; then IDLE, result_valid=0 next cycle; result keeps last value.
REQ-012 Products SHALL be 2*DATA_WIDTH bits; accumulation SHALL wrap modulo 2^ACC_WIDTH, no saturation, no error flag.
REQ-013 start SHALL be ignored in READ, DRAIN, DONE, including the handshake cycle; base_addr ignored except when start sampled in IDLE.
REQ-014 rd_en_mem1/2 SHALL be 0 in IDLE, DRAIN, DONE; rd_addr holds last value when rd_en=0.
REQ-015 busy SHALL be 1 in READ, DRAIN, DONE.

Reset
REQ-016 rst_n=0 at an edge SHALL force IDLE, busy=0, rd_en_mem1/2=0, rd_addr_mem1/2=0, element_count=0, result=0, result_valid=0, accumulator=0.
REQ-017 Reset mid-run SHALL abort with no further reads and no result_valid; rdata returning the next cycle SHALL be ignored.

Configuration
REQ-018 Macro DOT_PRODUCT_CTRL_SIGNED_EN defined: operands SHALL be two's-complement signed, products sign-extended to ACC_WIDTH; undefined: operands and products unsigned, zero-extended.

Verification
REQ-019 1-cycle-latency memory model, base 0, A=1,2,3,4, B=5,6,7,8, ready=1 -> addrs 0..3, result=70, element_count=4, result_valid at start+6 cycles.
REQ-020 A=10,20,30,40, B=2,4,6,8 -> result=600; A=0,15,0,25, B=3,0,7,0 -> result=0, result_valid still asserted.
REQ-021 result_ready=0 for 5 cycles in DONE, start pulsed meanwhile -> result_valid and result stable, no new reads; accepted on ready=1, IDLE next cycle.
REQ-022 base_addr=30 -> addresses 30,31,0,1 on both memories.
REQ-023 A=0xFF,2,3,4, B=5,6,7,8 -> result=60 with DOT_PRODUCT_CTRL_SIGNED_EN, 1340 without.
REQ-024 rst_n=0 during second READ cycle -> next cycle all outputs at reset values, no result_valid; fresh start afterwards gives correct result.

Source files
------------

// File: rtl/dot_product_ctrl.sv
// Dot-product sequencer: reads VECTOR_WIDTH element pairs from two 1-cycle-latency memories, multiply-accumulates, presents result.
// Latency: first read 1 cycle after start, result_valid VECTOR_WIDTH+2 cycles after start; result held until result_ready.
// Backpressure: holds DONE (result/element_count stable, start ignored) until result_valid && result_ready. Macro: DOT_PRODUCT_CTRL_SIGNED_EN.
module dot_product_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int VECTOR_WIDTH = 4,
    parameter int ADDR_WIDTH   = 5,
    parameter int ACC_WIDTH    = 18,
    parameter int CNT_WIDTH    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  rd_en_mem1,
    output logic [ADDR_WIDTH-1:0] rd_addr_mem1,
    output logic                  rd_en_mem2,
    output logic [ADDR_WIDTH-1:0] rd_addr_mem2,
    input  logic [DATA_WIDTH-1:0] mem1_rdata,
    input  logic [DATA_WIDTH-1:0] mem2_rdata,
    output logic [CNT_WIDTH-1:0]  element_count,
    output logic [ACC_WIDTH-1:0]  result,
    output logic                  result_valid,
    input  logic                  result_ready
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                  state;
    logic [CNT_WIDTH-1:0]    rd_cnt;
    logic                    rd_pend;
    logic [ACC_WIDTH-1:0]    acc;
    logic [2*DATA_WIDTH-1:0] op_a;
    logic [2*DATA_WIDTH-1:0] op_b;
    logic [2*DATA_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]    prod_ext;
    logic [ACC_WIDTH-1:0]    acc_sum;

    // Operands are widened to the product width first; the low half of the
    // product is then the correct two's-complement or unsigned result.
    always_comb begin
`ifdef DOT_PRODUCT_CTRL_SIGNED_EN
        op_a     = {{DATA_WIDTH{mem1_rdata[DATA_WIDTH-1]}}, mem1_rdata};
        op_b     = {{DATA_WIDTH{mem2_rdata[DATA_WIDTH-1]}}, mem2_rdata};
        prod     = op_a * op_b;
        prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
`else
        op_a     = {{DATA_WIDTH{1'b0}}, mem1_rdata};
        op_b     = {{DATA_WIDTH{1'b0}}, mem2_rdata};
        prod     = op_a * op_b;
        prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){1'b0}}, prod};
`endif
        acc_sum  = acc + prod_ext;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            busy          <= 1'b0;
            rd_en_mem1    <= 1'b0;
            rd_en_mem2    <= 1'b0;
            rd_addr_mem1  <= '0;
            rd_addr_mem2  <= '0;
            rd_cnt        <= '0;
            rd_pend       <= 1'b0;
            acc           <= '0;
            element_count <= '0;
            result        <= '0;
            result_valid  <= 1'b0;
        end else begin
            // rd_pend marks the cycle whose rdata answers last cycle's read.
            rd_pend <= rd_en_mem1;
            if (rd_pend) begin
                acc           <= acc_sum;
                element_count <= element_count + CNT_WIDTH'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= READ;
                        busy          <= 1'b1;
                        rd_en_mem1    <= 1'b1;
                        rd_en_mem2    <= 1'b1;
                        rd_addr_mem1  <= base_addr;
                        rd_addr_mem2  <= base_addr;
                        rd_cnt        <= '0;
                        acc           <= '0;
                        element_count <= '0;
                    end
                end
                READ: begin
                    if (rd_cnt == CNT_WIDTH'(VECTOR_WIDTH - 1)) begin
                        state      <= DRAIN;
                        rd_en_mem1 <= 1'b0;
                        rd_en_mem2 <= 1'b0;
                    end else begin
                        rd_cnt       <= rd_cnt + CNT_WIDTH'(1);
                        rd_addr_mem1 <= rd_addr_mem1 + ADDR_WIDTH'(1);
                        rd_addr_mem2 <= rd_addr_mem2 + ADDR_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    state        <= DONE;
                    result       <= acc_sum;
                    result_valid <= 1'b1;
                end
                DONE: begin
                    if (result_ready) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        result_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Directed + randomized bench for dot_product_ctrl against an integer-arithmetic reference model.
module tb_dot_product_ctrl;
    localparam int DW   = 8;
    localparam int VW   = 4;
    localparam int AW   = 5;
    localparam int ACCW = 18;
    localparam int CW   = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          busy;
    logic          rd_en_mem1, rd_en_mem2;
    logic [AW-1:0] rd_addr_mem1, rd_addr_mem2;
    logic [DW-1:0] mem1_rdata = '0;
    logic [DW-1:0] mem2_rdata = '0;
    logic [CW-1:0] element_count;
    logic [ACCW-1:0] result;
    logic          result_valid;
    logic          result_ready;

    always #5 clk = ~clk;

    dot_product_ctrl #(.DATA_WIDTH(DW), .VECTOR_WIDTH(VW), .ADDR_WIDTH(AW),
                       .ACC_WIDTH(ACCW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .busy(busy),
        .rd_en_mem1(rd_en_mem1), .rd_addr_mem1(rd_addr_mem1),
        .rd_en_mem2(rd_en_mem2), .rd_addr_mem2(rd_addr_mem2),
        .mem1_rdata(mem1_rdata), .mem2_rdata(mem2_rdata),
        .element_count(element_count), .result(result),
        .result_valid(result_valid), .result_ready(result_ready)
    );

    logic [DW-1:0] m1 [32];
    logic [DW-1:0] m2 [32];
    logic [DW-1:0] va [VW];
    logic [DW-1:0] vb [VW];

    always @(posedge clk) begin
        if (rd_en_mem1) mem1_rdata <= m1[rd_addr_mem1];
        if (rd_en_mem2) mem2_rdata <= m2[rd_addr_mem2];
    end

    int checks = 0;
    int errors = 0;
    int rd_q[$];
    int mis = 0;

    always @(negedge clk) begin
        if (rd_en_mem1 || rd_en_mem2) begin
            if (rd_en_mem1 !== rd_en_mem2 || rd_addr_mem1 !== rd_addr_mem2) mis++;
            rd_q.push_back(int'(rd_addr_mem1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint ext(input logic [DW-1:0] v);
`ifdef DOT_PRODUCT_CTRL_SIGNED_EN
        return longint'($signed(v));
`else
        return longint'(v);
`endif
    endfunction

    function automatic logic [31:0] ref_dot();
        longint     s = 0;
        logic [63:0] t;
        for (int i = 0; i < VW; i++) s += ext(va[i]) * ext(vb[i]);
        t = s;
        return {14'd0, t[ACCW-1:0]};
    endfunction

    task automatic load(input int base);
        for (int i = 0; i < 32; i++) begin
            m1[i] = DW'($urandom);
            m2[i] = DW'($urandom);
        end
        for (int i = 0; i < VW; i++) begin
            m1[(base + i) % 32] = va[i];
            m2[(base + i) % 32] = vb[i];
        end
    endtask

    task automatic run(input int base, input string tag, input logic [31:0] exp_res);
        int n;
        load(base);
        rd_q.delete();
        mis = 0;
        start = 1'b1;
        base_addr = AW'(base);
        tick();
        start = 1'b0;
        base_addr = AW'($urandom);
        chk($sformatf("%s first_rd_en", tag), 32'(rd_en_mem1), 1);
        chk($sformatf("%s busy", tag), 32'(busy), 1);
        n = 1;
        while (!result_valid && n < 20) begin
            tick();
            n++;
        end
        chk($sformatf("%s latency", tag), n, VW + 2);
        chk($sformatf("%s result", tag), 32'(result), exp_res);
        chk($sformatf("%s elem_cnt", tag), 32'(element_count), VW);
        chk($sformatf("%s nreads", tag), rd_q.size(), VW);
        for (int i = 0; i < VW && i < rd_q.size(); i++)
            chk($sformatf("%s addr%0d", tag, i), rd_q[i], (base + i) % 32);
        chk($sformatf("%s mem_match", tag), mis, 0);
        if (result_ready) begin
            tick();
            chk($sformatf("%s valid_drop", tag), 32'(result_valid), 0);
            chk($sformatf("%s idle", tag), 32'(busy), 0);
        end
    endtask

    task automatic set_vec(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < VW; i++) begin
            va[i] = a[8*i +: 8];
            vb[i] = b[8*i +: 8];
        end
    endtask

    initial begin
        logic [31:0] r;
        logic        seen;
        int          base;
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        result_ready = 1'b1;
        tick();
        tick();
        chk("rst busy", 32'(busy), 0);
        chk("rst rd_en", 32'({rd_en_mem1, rd_en_mem2}), 0);
        chk("rst result_valid", 32'(result_valid), 0);
        chk("rst result", 32'(result), 0);
        chk("rst elem_cnt", 32'(element_count), 0);
        rst_n = 1'b1;
        tick();

        set_vec(32'h04030201, 32'h08070605);
        run(0, "basic", 70);
        set_vec(32'h281E140A, 32'h08060402);
        run(7, "scaled", 600);
        set_vec(32'h19000F00, 32'h00070003);
        run(12, "zeros", 0);
        set_vec(32'h040302FF, 32'h08070605);
`ifdef DOT_PRODUCT_CTRL_SIGNED_EN
        run(3, "neg_op", 60);
`else
        run(3, "neg_op", 1340);
`endif
        set_vec(32'h44332211, 32'h88776655);
        run(30, "wrap_addr", ref_dot());

        for (int k = 0; k < 8; k++) begin
            set_vec($urandom, $urandom);
            run(int'($urandom_range(0, 31)), $sformatf("rand%0d", k), ref_dot());
        end

        // Consumer stalls in DONE while start is pulsed.
        result_ready = 1'b0;
        set_vec($urandom, $urandom);
        run(5, "stall", ref_dot());
        r = 32'(result);
        rd_q.delete();
        for (int k = 0; k < 5; k++) begin
            start = (k % 2 == 0);
            tick();
            chk($sformatf("stall valid%0d", k), 32'(result_valid), 1);
            chk($sformatf("stall hold%0d", k), 32'(result), r);
        end
        start = 1'b0;
        chk("stall elem_cnt", 32'(element_count), VW);
        chk("stall no_reads", rd_q.size(), 0);
        result_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("accept valid_drop", 32'(result_valid), 0);
        chk("accept idle", 32'(busy), 0);
        tick();
        chk("accept start_ignored", 32'(rd_en_mem1), 0);
        chk("accept result_kept", 32'(result), r);

        // Reset during the second READ cycle.
        set_vec($urandom, $urandom);
        load(9);
        start = 1'b1;
        base_addr = AW'(9);
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst busy", 32'(busy), 0);
        chk("midrst rd_en", 32'({rd_en_mem1, rd_en_mem2}), 0);
        chk("midrst addr", 32'({rd_addr_mem1, rd_addr_mem2}), 0);
        chk("midrst elem_cnt", 32'(element_count), 0);
        chk("midrst result", 32'(result), 0);
        chk("midrst valid", 32'(result_valid), 0);
        rd_q.delete();
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (result_valid) seen = 1'b1;
        end
        chk("midrst no_valid", 32'(seen), 0);
        chk("midrst no_reads", rd_q.size(), 0);
        base = int'($urandom_range(0, 31));
        set_vec($urandom, $urandom);
        run(base, "post_rst", ref_dot());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
